// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core: parity modes, TX/RX FSM states,
// majority-vote sample spacing.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   // Vote samples sit at mid-bit minus/plus this many ticks.
   localparam int MAJ_OFFSET = 1;

   function automatic parity_e decode_parity(input logic [1:0] cfg);
      case (cfg)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: free-running counter pulsing once every cfg_div+1 clocks.
// Latency: tick asserted combinationally from the counter state, one cycle wide.
// Backpressure: none; runs continuously, wraps on >= so a shrinking divisor cannot lock it up.
module uart_baud_tick #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt;

   assign tick = (cnt >= cfg_div);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: valid/ready byte stream <-> txd/rxd, runtime divisor, parity, 1/2 stop bits.
// Latency: txd start bit the cycle after accept; rx_valid one clock after the stop-bit vote tick.
// Backpressure: tx_ready low for the whole frame; RX holds one frame, later frames dropped and flagged as overrun.
module uart_core
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int DIV_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIV_WIDTH-1:0]  cfg_div,
   input  logic [1:0]            cfg_parity,
   input  logic                  cfg_stop2,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_busy,
   output logic                  txd,
   input  logic                  rxd,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_perr,
   output logic                  rx_ferr,
   output logic                  rx_overrun
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - MAJ_OFFSET);
   localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + MAJ_OFFSET);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

   logic tick;

   uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud_tick (
      .clk     (clk),
      .rst     (rst),
      .cfg_div (cfg_div),
      .tick    (tick)
   );

   // ---------------- transmitter ----------------
   tx_state_e             tx_state;
   logic [TW-1:0]         tx_tcnt;
   logic [BW-1:0]         tx_bcnt;
   logic [DATA_WIDTH-1:0] tx_shift;
   parity_e               tx_par;
   logic                  tx_stop2;
   logic                  tx_pbit;
   logic                  tx_bit_end;

   assign tx_bit_end = tick && (tx_tcnt == T_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         txd      <= 1'b1;
         tx_ready <= 1'b1;
         tx_busy  <= 1'b0;
         tx_tcnt  <= '0;
         tx_bcnt  <= '0;
         tx_shift <= '0;
         tx_par   <= PAR_NONE;
         tx_stop2 <= 1'b0;
         tx_pbit  <= 1'b0;
      end else begin
         if (tx_state != TX_IDLE && tick) begin
            tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + 1'b1;
         end
         case (tx_state)
            TX_IDLE: begin
               if (tx_valid && tx_ready) begin
                  tx_state <= TX_START;
                  txd      <= 1'b0;
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
                  tx_tcnt  <= '0;
                  tx_shift <= tx_data;
                  tx_par   <= decode_parity(cfg_parity);
                  tx_stop2 <= cfg_stop2;
                  tx_pbit  <= (decode_parity(cfg_parity) == PAR_ODD) ? ~^tx_data : ^tx_data;
               end
            end
            TX_START: begin
               if (tx_bit_end) begin
                  tx_state <= TX_DATA;
                  txd      <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_bcnt  <= '0;
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  if (tx_bcnt == B_LAST) begin
                     if (tx_par == PAR_NONE) begin
                        tx_state <= TX_STOP;
                        txd      <= 1'b1;
                     end else begin
                        tx_state <= TX_PARITY;
                        txd      <= tx_pbit;
                     end
                  end else begin
                     txd      <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                     tx_bcnt  <= tx_bcnt + 1'b1;
                  end
               end
            end
            TX_PARITY: begin
               if (tx_bit_end) begin
                  tx_state <= TX_STOP;
                  txd      <= 1'b1;
               end
            end
            TX_STOP: begin
               // tx_stop2 doubles as "one more stop bit pending".
               if (tx_bit_end) begin
                  if (tx_stop2) begin
                     tx_stop2 <= 1'b0;
                  end else begin
                     tx_state <= TX_IDLE;
                     tx_ready <= 1'b1;
                     tx_busy  <= 1'b0;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- receiver ----------------
   logic [SYNC_STAGES-1:0] rx_sync;
   logic                   rxd_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync <= '1;
      end else begin
         rx_sync <= {rx_sync[SYNC_STAGES-2:0], rxd};
      end
   end

   assign rxd_s = rx_sync[SYNC_STAGES-1];

   rx_state_e             rx_state;
   logic [TW-1:0]         rx_tcnt;
   logic [BW-1:0]         rx_bcnt;
   logic [DATA_WIDTH-1:0] rx_shift;
   parity_e               rx_par;
   logic                  rx_pbit;
   logic                  rx_s0;
   logic                  rx_s1;
   logic                  rx_vote;
   logic                  rx_vote_tick;
   logic                  rx_bit_end;
   logic                  rx_in_frame;
   logic                  rx_deliver;
   logic                  rx_perr_now;
   logic                  rx_hs;

   assign rx_vote      = maj3(rx_s0, rx_s1, rxd_s);
   assign rx_vote_tick = tick && (rx_tcnt == T_S2);
   assign rx_bit_end   = tick && (rx_tcnt == T_LAST);
   assign rx_in_frame  = (rx_state == RX_START) || (rx_state == RX_DATA) ||
                         (rx_state == RX_PARITY) || (rx_state == RX_STOP);
   assign rx_deliver   = (rx_state == RX_STOP) && rx_vote_tick;
   assign rx_hs        = rx_valid && rx_ready;

   always_comb begin
      rx_perr_now = 1'b0;
      case (rx_par)
         PAR_EVEN: rx_perr_now = (rx_pbit != ^rx_shift);
         PAR_ODD:  rx_perr_now = (rx_pbit != ~^rx_shift);
         default:  rx_perr_now = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_tcnt  <= '0;
         rx_bcnt  <= '0;
         rx_shift <= '0;
         rx_par   <= PAR_NONE;
         rx_pbit  <= 1'b0;
         rx_s0    <= 1'b1;
         rx_s1    <= 1'b1;
      end else begin
         if (rx_in_frame && tick) begin
            rx_tcnt <= rx_bit_end ? '0 : rx_tcnt + 1'b1;
            if (rx_tcnt == T_S0) rx_s0 <= rxd_s;
            if (rx_tcnt == T_S1) rx_s1 <= rxd_s;
         end
         case (rx_state)
            RX_IDLE: begin
               // The detecting tick is tick 0 of the start bit.
               if (tick && !rxd_s) begin
                  rx_state <= RX_START;
                  rx_tcnt  <= TW'(1);
                  rx_par   <= decode_parity(cfg_parity);
               end
            end
            RX_START: begin
               if (rx_vote_tick && rx_vote) begin
                  rx_state <= RX_IDLE;
               end else if (rx_bit_end) begin
                  rx_state <= RX_DATA;
                  rx_bcnt  <= '0;
               end
            end
            RX_DATA: begin
               if (rx_vote_tick) begin
                  rx_shift <= {rx_vote, rx_shift[DATA_WIDTH-1:1]};
               end
               if (rx_bit_end) begin
                  if (rx_bcnt == B_LAST) begin
                     rx_state <= (rx_par == PAR_NONE) ? RX_STOP : RX_PARITY;
                  end else begin
                     rx_bcnt <= rx_bcnt + 1'b1;
                  end
               end
            end
            RX_PARITY: begin
               if (rx_vote_tick) rx_pbit <= rx_vote;
               if (rx_bit_end) rx_state <= RX_STOP;
            end
            RX_STOP: begin
               if (rx_vote_tick) rx_state <= rx_vote ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
               if (rxd_s) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         rx_perr    <= 1'b0;
         rx_ferr    <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         if (rx_hs) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end
         if (rx_deliver) begin
            if (!rx_valid || rx_hs) begin
               rx_valid <= 1'b1;
               rx_data  <= rx_shift;
               rx_perr  <= rx_perr_now;
               rx_ferr  <= !rx_vote;
            end else begin
               rx_overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at cfg_div=3 (64 clk per bit): TX waveform, loopback,
// parity/framing/overrun flags, glitch rejection and asynchronous reset.
module tb_uart_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_div = 16'd3;
   logic [1:0]  cfg_parity = 2'b00;
   logic        cfg_stop2 = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic        tx_busy;
   logic        txd;
   logic        rxd;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        rx_perr;
   logic        rx_ferr;
   logic        rx_overrun;

   logic        loop = 1'b0;
   logic        rxd_drv = 1'b1;

   int checks = 0;
   int errors = 0;

   assign rxd = loop ? txd : rxd_drv;

   always #5 clk = ~clk;

   uart_core #(
      .DATA_WIDTH  (8),
      .OVERSAMPLE  (16),
      .DIV_WIDTH   (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_div    (cfg_div),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_busy    (tx_busy),
      .txd        (txd),
      .rxd        (rxd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_perr    (rx_perr),
      .rx_ferr    (rx_ferr),
      .rx_overrun (rx_overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive n serial bits on rxd, LSB first, 64 clocks each.
   task automatic drive_bits(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rxd_drv = bits[i];
         cycles(64);
      end
      rxd_drv = 1'b1;
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   initial begin
      int          n;
      logic [9:0]  tx_exp;
      logic [31:0] f;
      logic [7:0]  lb [3];

      // ---- reset state ----
      cycles(3);
      check("rst_txd", txd, 1'b1);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_tx_busy", tx_busy, 1'b0);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_flags", {rx_perr, rx_ferr, rx_overrun}, 3'b000);
      rst = 1'b0;
      cycles(3);

      // ---- TX 0xA5, even parity, one stop bit ----
      cfg_parity = 2'b01;
      cfg_stop2  = 1'b0;
      tx_data    = 8'hA5;
      tx_valid   = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_start_txd", txd, 1'b0);
      check("tx_start_ready", tx_ready, 1'b0);
      check("tx_start_busy", tx_busy, 1'b1);
      n = 0;
      while (txd !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tx_start_len_61_64", (n >= 61 && n <= 64), 1'b1);
      n = 0;
      while (txd !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tx_bit0_len", n, 64);
      cycles(32);
      check("tx_bit1", txd, 1'b0);
      tx_exp = {1'b1, 1'b0, 8'hA5};
      for (int k = 2; k < 10; k++) begin
         cycles(64);
         check($sformatf("tx_bit%0d", k), txd, tx_exp[k]);
      end
      cycles(31);
      check("tx_ready_before_stop_end", tx_ready, 1'b0);
      @(negedge clk);
      check("tx_ready_after_stop", tx_ready, 1'b1);
      check("tx_busy_after_stop", tx_busy, 1'b0);
      check("tx_idle_txd", txd, 1'b1);

      // ---- loopback, odd parity, two stop bits, back-to-back ----
      cfg_parity = 2'b10;
      cfg_stop2  = 1'b1;
      loop       = 1'b1;
      lb[0] = 8'h00;
      lb[1] = 8'hFF;
      lb[2] = 8'h3C;
      fork
         begin
            int sn;
            for (int k = 0; k < 3; k++) begin
               tx_data  = lb[k];
               tx_valid = 1'b1;
               sn = 0;
               while (!tx_ready && sn < 1500) begin
                  @(negedge clk);
                  sn++;
               end
               check("lb_tx_accept", (sn < 1500), 1'b1);
               @(negedge clk);
            end
            tx_valid = 1'b0;
         end
         begin
            int rn;
            for (int k = 0; k < 3; k++) begin
               rn = 0;
               while (!rx_valid && rn < 2000) begin
                  @(negedge clk);
                  rn++;
               end
               check("lb_rx_valid", rx_valid, 1'b1);
               check("lb_rx_data", rx_data, lb[k]);
               check("lb_rx_flags", {rx_perr, rx_ferr, rx_overrun}, 3'b000);
               consume();
            end
         end
      join
      n = 0;
      while (!tx_ready && n < 1500) begin
         @(negedge clk);
         n++;
      end
      check("lb_tx_done", tx_ready, 1'b1);
      loop = 1'b0;
      cfg_stop2 = 1'b0;
      cycles(64);

      // ---- parity error: 0x55 even with parity bit 1 ----
      cfg_parity = 2'b01;
      f = {21'd0, 1'b1, 1'b1, 8'h55, 1'b0};
      drive_bits(f, 11);
      check("perr_valid", rx_valid, 1'b1);
      check("perr_data", rx_data, 8'h55);
      check("perr_flag", rx_perr, 1'b1);
      check("perr_ferr", rx_ferr, 1'b0);
      consume();
      check("perr_valid_cleared", rx_valid, 1'b0);

      // ---- framing error followed by a held-low line ----
      cfg_parity = 2'b00;
      f = {19'd0, 3'b000, 1'b0, 8'hC3, 1'b0};
      drive_bits(f, 13);
      check("ferr_valid", rx_valid, 1'b1);
      check("ferr_data", rx_data, 8'hC3);
      check("ferr_flag", rx_ferr, 1'b1);
      check("ferr_perr", rx_perr, 1'b0);
      consume();
      cycles(12 * 64);
      check("ferr_no_rearm_frame", rx_valid, 1'b0);
      f = {22'd0, 1'b1, 8'h5A, 1'b0};
      drive_bits(f, 10);
      check("ferr_recover_valid", rx_valid, 1'b1);
      check("ferr_recover_data", rx_data, 8'h5A);
      check("ferr_recover_flag", rx_ferr, 1'b0);
      consume();

      // ---- overrun: two frames with no consumer ----
      f = {12'd0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
      drive_bits(f, 20);
      check("ovr_valid", rx_valid, 1'b1);
      check("ovr_data_kept", rx_data, 8'h11);
      check("ovr_flag", rx_overrun, 1'b1);
      consume();
      check("ovr_valid_cleared", rx_valid, 1'b0);
      check("ovr_flag_cleared", rx_overrun, 1'b0);

      // ---- 4-clock glitch on rxd ----
      rxd_drv = 1'b0;
      cycles(4);
      rxd_drv = 1'b1;
      cycles(3 * 64);
      check("glitch_no_valid", rx_valid, 1'b0);

      // ---- asynchronous reset mid-TX ----
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      cycles(200);
      check("pre_rst_txd_low", txd, 1'b0);
      check("pre_rst_busy", tx_busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_txd", txd, 1'b1);
      check("rst_mid_ready", tx_ready, 1'b1);
      check("rst_mid_busy", tx_busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      cycles(200);
      check("post_rst_txd_idle", txd, 1'b1);
      check("post_rst_no_rx", rx_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
